// File: rtl/fixed_accumulator_pkg.sv
// rtl/fixed_accumulator_pkg.sv - shared width helpers for the accumulator and its beat counter
package fixed_accumulator_pkg;

  // Result width grows by log2(depth) so the sum of depth full-scale beats never overflows.
  function automatic int acc_out_width(input int in_width, input int in_depth);
    return in_width + $clog2(in_depth);
  endfunction

  // Counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int in_depth);
    return $clog2(in_depth) + 1;
  endfunction

endpackage

// File: rtl/fixed_accumulator_beat_counter.sv
// rtl/fixed_accumulator_beat_counter.sv - modulo beat counter with clear, load-one and full flag
module beat_counter
  import fixed_accumulator_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int WIDTH = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  input  logic             load_one,
  output logic [WIDTH-1:0] count,
  output logic             full
);

  assign full = (count == WIDTH'(DEPTH));

  // load_one covers a completed group being drained while a new first beat arrives.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= WIDTH'(1);
    end else if (inc) begin
      count <= full ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fixed_accumulator.sv
// rtl/fixed_accumulator.sv - sums IN_DEPTH accepted beats and presents the total on a valid/ready output
// Optional FIXED_ACCUMULATOR_SIGNED_EN: treat data_in as two's complement and sign-extend it.
module fixed_accumulator
  import fixed_accumulator_pkg::*;
#(
  parameter  int IN_WIDTH  = 16,
  parameter  int IN_DEPTH  = 4,
  localparam int OUT_WIDTH = acc_out_width(IN_WIDTH, IN_DEPTH),
  localparam int CNT_WIDTH = cnt_width(IN_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] ext_in;
  logic                 inc;
  logic                 clear;
  logic                 load_one;

`ifdef FIXED_ACCUMULATOR_SIGNED_EN
  assign ext_in = OUT_WIDTH'($signed(data_in));
`else
  assign ext_in = OUT_WIDTH'(data_in);
`endif

  assign data_out       = acc;
  assign data_out_valid = full;
  assign data_in_ready  = !full || data_out_ready;

  // A drained result is immediately replaced by the next group's first beat, so there are no bubbles.
  assign inc      = data_in_valid && !full;
  assign load_one = full && data_out_ready && data_in_valid;
  assign clear    = full && data_out_ready && !data_in_valid;

  beat_counter #(
    .DEPTH(IN_DEPTH)
  ) u_beat_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .clear   (clear),
    .load_one(load_one),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (load_one) begin
      acc <= ext_in;
    end else if (inc) begin
      acc <= acc + ext_in;
    end
  end

endmodule

// File: tb/tb_fixed_accumulator.sv
// tb/tb_fixed_accumulator.sv - scoreboard bench for fixed_accumulator with a behavioural sum model
module tb_fixed_accumulator;

  localparam int IN_WIDTH  = 8;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_WIDTH = 10;
  localparam int MASK      = (1 << OUT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [IN_WIDTH-1:0]  data_in = '0;
  logic                 data_in_valid = 1'b0;
  logic                 data_in_ready;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt = 0;
  int m_sum = 0;
  bit m_pending = 1'b0;
  int exp_q[$];

  fixed_accumulator #(
    .IN_WIDTH(IN_WIDTH),
    .IN_DEPTH(IN_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int ext(input logic [IN_WIDTH-1:0] d);
`ifdef FIXED_ACCUMULATOR_SIGNED_EN
    return int'($signed(d));
`else
    return int'(d);
`endif
  endfunction

  // Reference model: a result is outstanding after every IN_DEPTH-th accepted beat until the consumer takes it.
  always @(negedge clk) begin
    bit exp_ready;
    if (rst) begin
      m_cnt = 0;
      m_sum = 0;
      m_pending = 1'b0;
      exp_q.delete();
    end else begin
      exp_ready = !m_pending || data_out_ready;
      check("out_valid", int'(data_out_valid), int'(m_pending));
      check("in_ready", int'(data_in_ready), int'(exp_ready));
      if (m_pending && data_out_ready) m_pending = 1'b0;
      if (data_in_valid && exp_ready) begin
        m_sum += ext(data_in);
        m_cnt++;
        if (m_cnt == IN_DEPTH) begin
          exp_q.push_back(m_sum & MASK);
          m_pending = 1'b1;
          m_cnt = 0;
          m_sum = 0;
        end
      end
    end
  end

  // Monitor: data_out must equal the oldest outstanding result for every cycle it is valid.
  always @(negedge clk) begin
    if (!rst && data_out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", int'(data_out), -1);
      end else begin
        check("data_out", int'(data_out), exp_q[0]);
        if (data_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [IN_WIDTH-1:0] d, input logic v, input logic r);
    data_in        = d;
    data_in_valid  = v;
    data_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vec[4];
    // Reset held while a beat is offered: nothing may be counted.
    rst = 1'b1;
    data_in = 8'd99;
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    data_in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(data_out_valid), 0);
    check("rst_in_ready", int'(data_in_ready), 1);
    check("rst_data_out", int'(data_out), 0);
    @(posedge clk);
    #1;

`ifdef FIXED_ACCUMULATOR_SIGNED_EN
    vec = '{-128, -1, 127, -3};
    foreach (vec[i]) drive(IN_WIDTH'(vec[i]), 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    check("signed_sum", int'(data_out), 'h3FB);
    @(posedge clk);
    #1;
    drive('0, 1'b0, 1'b1);
`endif

    // Basic sum 10,20,30,255 = 315.
    vec = '{10, 20, 30, 255};
    foreach (vec[i]) drive(IN_WIDTH'(vec[i]), 1'b1, 1'b1);
    drive('0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);

    // Backpressure: result held, beat 7 refused until the consumer is ready.
    foreach (vec[i]) drive(IN_WIDTH'(vec[i]), 1'b1, 1'b0);
    repeat (3) drive(8'd7, 1'b1, 1'b0);
    drive(8'd7, 1'b1, 1'b1);
    drive(8'd1, 1'b1, 1'b1);
    drive(8'd2, 1'b1, 1'b1);
    drive(8'd3, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b1);

    // Continuous streaming of three vectors with no idle cycles.
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++) drive((g == 0) ? 8'd1 : (g == 1) ? 8'd2 : 8'd255, 1'b1, 1'b1);
    end
    drive('0, 1'b0, 1'b1);

    // Gapped input: the counter holds during idle cycles.
    for (int b = 0; b < 4; b++) begin
      drive(8'd5, 1'b1, 1'b1);
      drive(8'd77, 1'b0, 1'b1);
    end
    drive('0, 1'b0, 1'b1);

    // Mid-accumulation reset discards the partial sum.
    drive(8'd200, 1'b1, 1'b1);
    drive(8'd200, 1'b1, 1'b1);
    rst = 1'b1;
    drive('0, 1'b0, 1'b1);
    rst = 1'b0;
    vec = '{1, 2, 3, 4};
    foreach (vec[i]) drive(IN_WIDTH'(vec[i]), 1'b1, 1'b1);
    drive('0, 1'b0, 1'b1);

    // Randomised valid, ready and data.
    for (int c = 0; c < 600; c++) begin
      drive(IN_WIDTH'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    // Drain: every produced result must have been consumed.
    repeat (8) drive('0, 1'b0, 1'b1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fixed_accumulator.md
Name: fixed_accumulator

Overview:
- Streaming accumulator: sums exactly IN_DEPTH consecutive accepted input beats into one result, then presents that result on a valid/ready output.
- Sits after a per-block adder tree in the softmax datapath and produces the per-vector sum of exponentials used as the divisor.
- Pure handshake block: it has no internal storage beyond the running sum and a beat counter.

Parameters:
- IN_WIDTH, 16: width of each input beat.
- IN_DEPTH, 4: number of beats per accumulation (≥1).
- OUT_WIDTH, IN_WIDTH+$clog2(IN_DEPTH): width of the result (localparam; not overridable). This is the growth needed so the sum never overflows.
- CNT_WIDTH, $clog2(IN_DEPTH)+1: beat counter width (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  IN_WIDTH  input beat.
- data_in_valid  input  1  producer has a beat.
- data_in_ready  output  1  block accepts a beat this cycle.
- data_out  output  OUT_WIDTH  accumulated sum.
- data_out_valid  output  1  sum of IN_DEPTH beats available.
- data_out_ready  input  1  consumer accepts the sum.

Behaviour:
- State consists of two registers only:
  - counter[CNT_WIDTH], range 0..IN_DEPTH.
  - acc[OUT_WIDTH].
- Reset (rst=1 at a clock edge): counter=0, acc=0. As a consequence, data_out_valid=0, data_in_ready=1 and data_out=0. Reset mid-accumulation discards any partial sum.
- Combinational outputs:
  - data_out = acc.
  - data_out_valid = (counter==IN_DEPTH).
  - data_in_ready = (counter!=IN_DEPTH) || data_out_ready.
- Accumulating (counter<IN_DEPTH):
  - An input handshake (data_in_valid && data_in_ready) sets acc <= acc + ext(data_in) and counter <= counter+1.
  - With no handshake, state holds.
- Full (counter==IN_DEPTH):
  - If data_out_ready=0: state holds and data_in_ready=0 (backpressure). data_out must stay stable.
  - If data_out_ready=1 and data_in_valid=1: output and input handshake in the same cycle. Next state is acc <= ext(data_in), counter <= 1. There are no bubbles.
  - If data_out_ready=1 and data_in_valid=0: acc <= 0, counter <= 0.
- Latency and throughput:
  - Result is valid the cycle after the IN_DEPTH-th input handshake.
  - Sustained throughput is one beat per cycle, with results every IN_DEPTH cycles.
- IN_DEPTH=1: the block acts as a 1-deep register stage with full throughput.
- ext(): zero-extension to OUT_WIDTH by default. The addition wraps modulo 2^OUT_WIDTH, which cannot occur for in-range inputs.
- Valid must not depend combinationally on data_out_ready. Ready may depend on data_out_ready.

Optional Feature:
- Macro: FIXED_ACCUMULATOR_SIGNED_EN.
- Defined: data_in is treated as two's complement. ext() sign-extends, and acc/data_out are two's-complement OUT_WIDTH values.
- Undefined (default): unsigned. ext() zero-extends.
- Handshake and timing are identical in both modes.

Decomposition:
- Shared package fixed_accumulator_pkg holds:
  - function acc_out_width(in_width, in_depth) returning in_width+$clog2(in_depth).
  - function cnt_width(in_depth).
- One natural sub-module: beat_counter. It is a modulo counter with inputs inc, clear, load_one; output count; and flag full when count==IN_DEPTH. It is reused by the adder-tree and roller blocks.
- The sum register stays in fixed_accumulator.

Test Plan:
- Reset: assert rst for 2 cycles while data_in_valid=1 → data_out_valid=0, data_in_ready=1, data_out=0; no beats counted.
- Basic sum, IN_WIDTH=8, IN_DEPTH=4, unsigned: feed 10,20,30,255 back-to-back with data_out_ready=1 → data_out_valid=1 one cycle after the 4th beat, data_out=315 (10 bits). Valid lasts one cycle.
- Backpressure: same stream with data_out_ready=0 → valid stays 1, data_out holds 315, data_in_ready=0, an extra beat of 7 is not absorbed. Raising ready accepts 7 in the same cycle, and the next result equals 7 plus the following three beats.
- Continuous streaming: 3 vectors of {1,1,1,1},{2,2,2,2},{255×4} with no idle cycles → results 4, 8, 1020 on cycles 5, 9, 13. No dropped beats.
- Gapped input: valid toggling 1/0 with 4 beats of 5 → result 20. The counter holds during gaps.
- FIXED_ACCUMULATOR_SIGNED_EN, IN_WIDTH=8, IN_DEPTH=4: inputs -128,-1,127,-3 → data_out = -5, i.e. 10'h3FB.
